// File: rtl/cpu_control_fsm.sv
// Control unit for the register-bank/ALU datapath. Each instruction takes at
// least three cycles: fetch, decode, execute. ALU flags close the loop through psr.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FETCH   | request instruction at pc, wait for instr_valid, capture IR
// DECODE  | load registered datapath controls from IR
// EXECUTE | one-cycle write pulse, latch flags, advance or branch pc
// HALT    | core stopped until reset
module cpu_control_fsm #(
   parameter int               PC_W     = 16,
   parameter logic [PC_W-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [15:0]     instr,
   input  logic            instr_valid,
   input  logic [4:0]      Flags_in,
   output logic [PC_W-1:0] pc,
   output logic            fetch_req,
   output logic [15:0]     wEnable,
   output logic [15:0]     Imm_in,
   output logic [7:0]      opcode,
   output logic [3:0]      Rdest_select,
   output logic [3:0]      Rsrc_select,
   output logic            Imm_select,
   output logic [4:0]      psr,
   output logic            halted
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [7:0]      opcode_q, opcode_d;
   logic [3:0]      rdest_q, rdest_d;
   logic [3:0]      rsrc_q, rsrc_d;
   logic [15:0]     imm_q, imm_d;
   logic            imm_sel_q, imm_sel_d;
   logic            wr_q, wr_d;
   logic            alu_q, alu_d;
   logic [4:0]      psr_q, psr_d;
   logic            fetch_req_q, fetch_req_d;

   logic [PC_W-1:0] disp;
   logic            taken;

   assign disp = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};

   // Branch conditions read psr only, so they see the previous ALU result.
   always_comb begin
      taken = 1'b0;
      case (ir_q[11:8])
         4'b0000: taken = psr_q[1];
         4'b0001: taken = ~psr_q[1];
         4'b1110: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         opcode_q    <= '0;
         rdest_q     <= '0;
         rsrc_q      <= '0;
         imm_q       <= '0;
         imm_sel_q   <= 1'b1;
         wr_q        <= 1'b0;
         alu_q       <= 1'b0;
         psr_q       <= '0;
         fetch_req_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         opcode_q    <= opcode_d;
         rdest_q     <= rdest_d;
         rsrc_q      <= rsrc_d;
         imm_q       <= imm_d;
         imm_sel_q   <= imm_sel_d;
         wr_q        <= wr_d;
         alu_q       <= alu_d;
         psr_q       <= psr_d;
         fetch_req_q <= fetch_req_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      opcode_d  = opcode_q;
      rdest_d   = rdest_q;
      rsrc_d    = rsrc_q;
      imm_d     = imm_q;
      imm_sel_d = imm_sel_q;
      wr_d      = wr_q;
      alu_d     = alu_q;
      psr_d     = psr_q;

      case (state_q)
         S_FETCH: begin
            if (fetch_req_q && instr_valid) begin
               ir_d    = instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            wr_d    = 1'b0;
            alu_d   = 1'b0;
            state_d = S_EXECUTE;
            case (ir_q[15:12])
               4'b0000: begin
                  opcode_d  = {4'b0000, ir_q[7:4]};
                  rdest_d   = ir_q[11:8];
                  rsrc_d    = ir_q[3:0];
                  imm_sel_d = 1'b1;
                  alu_d     = 1'b1;
                  wr_d      = (ir_q[7:4] != 4'b1011);
               end
               4'b0101, 4'b1001, 4'b1011: begin
                  opcode_d  = {ir_q[15:12], 4'b0000};
                  rdest_d   = ir_q[11:8];
                  imm_d     = {{8{ir_q[7]}}, ir_q[7:0]};
                  imm_sel_d = 1'b0;
                  alu_d     = 1'b1;
                  wr_d      = (ir_q[15:12] != 4'b1011);
               end
               4'b0001, 4'b0010, 4'b0011, 4'b1101: begin
                  opcode_d  = {ir_q[15:12], 4'b0000};
                  rdest_d   = ir_q[11:8];
                  imm_d     = {8'h00, ir_q[7:0]};
                  imm_sel_d = 1'b0;
                  alu_d     = 1'b1;
                  wr_d      = 1'b1;
               end
               default: begin
               end
            endcase
         end
         S_EXECUTE: begin
            if (alu_q) psr_d = Flags_in;
            if (ir_q[15:12] == 4'b1111) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
               if (ir_q[15:12] == 4'b1100 && taken) pc_d = pc_q + disp;
               else                                 pc_d = pc_q + PC_W'(1);
            end
         end
         S_HALT: begin
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Registered so fetch_req stays low for the first cycle after reset release.
   assign fetch_req_d = (state_d == S_FETCH);

   assign pc           = pc_q;
   assign fetch_req    = fetch_req_q;
   assign wEnable      = (state_q == S_EXECUTE && wr_q) ? (16'h0001 << rdest_q) : 16'h0000;
   assign Imm_in       = imm_q;
   assign opcode       = opcode_q;
   assign Rdest_select = rdest_q;
   assign Rsrc_select  = rsrc_q;
   assign Imm_select   = imm_sel_q;
   assign psr          = psr_q;
   assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: a vector table of instructions with
// hand-computed controls, write enables, psr and next pc, plus reset/halt sequences.
module tb_cpu_control_fsm;

   logic        clk;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic [4:0]  Flags_in;
   logic [15:0] pc;
   logic        fetch_req;
   logic [15:0] wEnable;
   logic [15:0] Imm_in;
   logic [7:0]  opcode;
   logic [3:0]  Rdest_select;
   logic [3:0]  Rsrc_select;
   logic        Imm_select;
   logic [4:0]  psr;
   logic        halted;

   int n_pass  = 0;
   int n_total = 0;

   cpu_control_fsm #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .Flags_in     (Flags_in),
      .pc           (pc),
      .fetch_req    (fetch_req),
      .wEnable      (wEnable),
      .Imm_in       (Imm_in),
      .opcode       (opcode),
      .Rdest_select (Rdest_select),
      .Rsrc_select  (Rsrc_select),
      .Imm_select   (Imm_select),
      .psr          (psr),
      .halted       (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic [4:0]  flags;
      int          stall;
      logic        chk;
      logic [7:0]  op;
      logic        sel;
      logic [3:0]  rdest;
      logic [15:0] imm;
      logic [3:0]  rsrc;
      logic [15:0] wen;
      logic [4:0]  psr_after;
      logic [15:0] pc_after;
      logic        halt;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fetch(input string tag);
      int n = 0;
      while (fetch_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, " fetch_req wait"}, {31'd0, fetch_req}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [15:0] pc0;
      wait_fetch(tag);
      pc0 = pc;
      for (int s = 0; s < v.stall; s++) begin
         instr_valid = 1'b0;
         tick();
         check({tag, " stall fetch_req"}, {31'd0, fetch_req}, 32'd1);
         check({tag, " stall pc"}, {16'd0, pc}, {16'd0, pc0});
         check({tag, " stall wEnable"}, {16'd0, wEnable}, 32'd0);
      end
      instr       = v.instr;
      Flags_in    = v.flags;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      check({tag, " decode fetch_req"}, {31'd0, fetch_req}, 32'd0);
      check({tag, " decode wEnable"}, {16'd0, wEnable}, 32'd0);
      tick();
      check({tag, " exec wEnable"}, {16'd0, wEnable}, {16'd0, v.wen});
      if (v.chk) begin
         check({tag, " opcode"}, {24'd0, opcode}, {24'd0, v.op});
         check({tag, " Imm_select"}, {31'd0, Imm_select}, {31'd0, v.sel});
         check({tag, " Rdest_select"}, {28'd0, Rdest_select}, {28'd0, v.rdest});
         if (v.sel == 1'b0) check({tag, " Imm_in"}, {16'd0, Imm_in}, {16'd0, v.imm});
         else               check({tag, " Rsrc_select"}, {28'd0, Rsrc_select}, {28'd0, v.rsrc});
      end
      tick();
      check({tag, " post wEnable"}, {16'd0, wEnable}, 32'd0);
      check({tag, " psr"}, {27'd0, psr}, {27'd0, v.psr_after});
      check({tag, " pc"}, {16'd0, pc}, {16'd0, v.pc_after});
      check({tag, " halted"}, {31'd0, halted}, {31'd0, v.halt});
   endtask

   function automatic vec_t mk(input logic [15:0] i, input logic [4:0] f, input int st,
                               input logic c, input logic [7:0] op, input logic sel,
                               input logic [3:0] rd, input logic [15:0] imm, input logic [3:0] rs,
                               input logic [15:0] wen, input logic [4:0] p, input logic [15:0] npc,
                               input logic h);
      vec_t v;
      v.instr = i; v.flags = f; v.stall = st; v.chk = c; v.op = op; v.sel = sel;
      v.rdest = rd; v.imm = imm; v.rsrc = rs; v.wen = wen; v.psr_after = p;
      v.pc_after = npc; v.halt = h;
      return v;
   endfunction

   initial begin
      vec_t cmp_pre;
      vec_t hv;
      reset       = 1'b0;
      instr       = 16'h0000;
      instr_valid = 1'b0;
      Flags_in    = 5'b0;

      //           instr    flags  st c  op   sel rd   imm      rs   wen      psr    pc      halt
      vecs[0]  = mk(16'h53FF, 5'b10000, 0, 1, 8'h50, 0, 4'h3, 16'hFFFF, 4'h0, 16'h0008, 5'b10000, 16'h0001, 0);
      vecs[1]  = mk(16'h0255, 5'b00000, 0, 1, 8'h05, 1, 4'h2, 16'h0000, 4'h5, 16'h0004, 5'b00000, 16'h0002, 0);
      vecs[2]  = mk(16'h1280, 5'b00001, 0, 1, 8'h10, 0, 4'h2, 16'h0080, 4'h0, 16'h0004, 5'b00001, 16'h0003, 0);
      vecs[3]  = mk(16'h7000, 5'b11111, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b00001, 16'h0004, 0);
      vecs[4]  = mk(16'hB407, 5'b00010, 0, 1, 8'hB0, 0, 4'h4, 16'h0007, 4'h0, 16'h0000, 5'b00010, 16'h0005, 0);
      vecs[5]  = mk(16'hC0FE, 5'b00000, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b00010, 16'h0003, 0);
      vecs[6]  = mk(16'hB407, 5'b00000, 0, 1, 8'hB0, 0, 4'h4, 16'h0007, 4'h0, 16'h0000, 5'b00000, 16'h0004, 0);
      vecs[7]  = mk(16'h7000, 5'b00000, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b00000, 16'h0005, 0);
      vecs[8]  = mk(16'hC0FE, 5'b00000, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b00000, 16'h0006, 0);
      vecs[9]  = mk(16'h02B1, 5'b00010, 4, 1, 8'h0B, 1, 4'h2, 16'h0000, 4'h1, 16'h0000, 5'b00010, 16'h0007, 0);
      vecs[10] = mk(16'hC1F0, 5'b00000, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b00010, 16'h0008, 0);
      vecs[11] = mk(16'hD5A5, 5'b00000, 0, 1, 8'hD0, 0, 4'h5, 16'h00A5, 4'h0, 16'h0020, 5'b00000, 16'h0009, 0);
      vecs[12] = mk(16'hC1F6, 5'b00000, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b00000, 16'hFFFF, 0);
      vecs[13] = mk(16'h7000, 5'b00000, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b00000, 16'h0000, 0);
      vecs[14] = mk(16'h9F80, 5'b00000, 0, 1, 8'h90, 0, 4'hF, 16'hFF80, 4'h0, 16'h8000, 5'b00000, 16'h0001, 0);
      vecs[15] = mk(16'hC205, 5'b00000, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b00000, 16'h0002, 0);
      vecs[16] = mk(16'h3A7F, 5'b01000, 1, 1, 8'h30, 0, 4'hA, 16'h007F, 4'h0, 16'h0400, 5'b01000, 16'h0003, 0);

      // Reset values
      #12;
      check("rst pc", {16'd0, pc}, 32'd0);
      check("rst fetch_req", {31'd0, fetch_req}, 32'd0);
      check("rst wEnable", {16'd0, wEnable}, 32'd0);
      check("rst opcode", {24'd0, opcode}, 32'd0);
      check("rst Imm_in", {16'd0, Imm_in}, 32'd0);
      check("rst Rdest", {28'd0, Rdest_select}, 32'd0);
      check("rst Rsrc", {28'd0, Rsrc_select}, 32'd0);
      check("rst Imm_select", {31'd0, Imm_select}, 32'd1);
      check("rst psr", {27'd0, psr}, 32'd0);
      check("rst halted", {31'd0, halted}, 32'd0);

      // Reset asserted in the middle of an ADDI execute cycle
      tick();
      reset = 1'b1;
      tick();
      check("post-release fetch_req", {31'd0, fetch_req}, 32'd1);
      cmp_pre = mk(16'hB407, 5'b00010, 0, 1, 8'hB0, 0, 4'h4, 16'h0007, 4'h0, 16'h0000, 5'b00010, 16'h0001, 0);
      run_vec(cmp_pre, "pre-cmpi");
      wait_fetch("abort");
      instr       = 16'h53FF;
      Flags_in    = 5'b11111;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      check("abort exec wEnable", {16'd0, wEnable}, 32'h0008);
      reset = 1'b0;
      #1;
      check("abort wEnable", {16'd0, wEnable}, 32'd0);
      check("abort pc", {16'd0, pc}, 32'd0);
      check("abort psr", {27'd0, psr}, 32'd0);
      check("abort fetch_req", {31'd0, fetch_req}, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("release fetch_req low", {31'd0, fetch_req}, 32'd0);
      tick();
      check("release fetch_req high", {31'd0, fetch_req}, 32'd1);

      for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Branch-always at pc 3 lands on pc 6, then HALT there
      hv = mk(16'hCE03, 5'b00000, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b01000, 16'h0006, 0);
      run_vec(hv, "bal");
      hv = mk(16'hF000, 5'b10101, 0, 0, 8'h00, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 5'b01000, 16'h0006, 1);
      run_vec(hv, "halt");
      instr       = 16'h53FF;
      instr_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("halt%0d halted", c), {31'd0, halted}, 32'd1);
         check($sformatf("halt%0d fetch_req", c), {31'd0, fetch_req}, 32'd0);
         check($sformatf("halt%0d wEnable", c), {16'd0, wEnable}, 32'd0);
         check($sformatf("halt%0d pc", c), {16'd0, pc}, 32'h0006);
      end
      instr_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Control unit that drives the register-bank/ALU datapath.
- Fetches a 16-bit instruction, decodes it into that datapath's control inputs, and pulses a one-hot register write enable.
- Latches the datapath's 5-bit ALU flags into a status register and resolves conditional branches from it.
- Sits between instruction memory and the datapath, closing the loop on flags.

Parameters:
PC_W, 16, width of program counter / fetch address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
instr  input  16  instruction word from memory, sampled when instr_valid=1 in FETCH
instr_valid  input  1  memory has instr for the current pc
Flags_in  input  5  datapath ALU flags {C,L,F,Z,N} (bit4..bit0), combinational from current controls
pc  output  PC_W  fetch address
fetch_req  output  1  request instruction at pc
wEnable  output  16  one-hot register write enable to datapath
Imm_in  output  16  extended immediate to datapath
opcode  output  8  ALU opcode to datapath
Rdest_select  output  4  destination/first-operand register index
Rsrc_select  output  4  source register index
Imm_select  output  1  0 = ALU second operand is Imm_in, 1 = Rsrc register
psr  output  5  latched flags {C,L,F,Z,N}
halted  output  1  core stopped

Behaviour:
- Reset (reset=0, async): state=FETCH; pc=RESET_PC.
- Reset (cont.): wEnable, Imm_in, opcode, Rdest_select, Rsrc_select, psr = 0; Imm_select=1; halted=0; fetch_req=0.
- Reset mid-instruction aborts it with no write.
- FETCH:
  - fetch_req=1.
  - Hold until instr_valid=1, then capture instr into IR → DECODE.
  - pc unchanged while stalled.
- DECODE: fetch_req=0; registered control outputs are loaded from IR, held stable through EXECUTE. Decoding by IR[15:12]:
  - 0000 register ALU:
    - opcode={0000,IR[7:4]}, Rdest_select=IR[11:8], Rsrc_select=IR[3:0], Imm_select=1.
    - Writes Rdest unless IR[7:4]=1011 (CMP).
  - 0101 ADDI, 1001 SUBI, 1011 CMPI, 0001 ANDI, 0010 ORI, 0011 XORI, 1101 MOVI:
    - opcode={IR[15:12],0000}, Rdest_select=IR[11:8], Imm_select=0.
    - Imm_in = sign-extended IR[7:0] for ADDI/SUBI/CMPI; zero-extended for ANDI/ORI/XORI/MOVI.
    - CMPI writes nothing.
  - 1100 Bcond: cond=IR[11:8], disp=sign-extended IR[7:0]; no ALU write.
  - 1111 HALT.
  - Any other value: NOP.
- EXECUTE (exactly one cycle), then FETCH:
  - wEnable=1<<Rdest_select for writing classes, 0 otherwise. Never nonzero outside EXECUTE.
  - All ALU classes, CMP/CMPI included, latch psr<=Flags_in at the end of EXECUTE.
  - Bcond taken → pc<=pc+disp (mod 2^PC_W); otherwise pc<=pc+1 (wraps FFFF→0 at PC_W=16).
  - Conditions use psr: 0000 EQ (Z=1), 0001 NE (Z=0), 1110 always; all other codes not taken.
  - HALT → HALT state, pc unchanged.
- HALT:
  - halted=1, fetch_req=0, wEnable=0.
  - Left only by reset.
- Timing:
  - Minimum 3 cycles per instruction (FETCH with instr_valid already high, DECODE, EXECUTE).
  - Branches are not flag-forwarded: a branch sees psr as latched by the previous ALU instruction.

Test Plan:
1. reset=0 asserted during EXECUTE of an ADDI → wEnable drops to 0 immediately, pc=RESET_PC, psr=0; after release fetch_req=1 next cycle.
2. pc=0, instr 16'h53FF (ADDI R3,-1) → in EXECUTE opcode=8'h50, Imm_in=16'hFFFF, Imm_select=0, Rdest_select=3, wEnable=16'h0008 for exactly one cycle; pc becomes 1.
3. instr 16'h0255 (reg ADD R2,R5) → opcode=8'h05, Rsrc_select=5, Imm_select=1, wEnable=16'h0004 once; ANDI 16'h1280 → Imm_in=16'h0080 (zero-extended).
4. CMPI 16'hB407 with Flags_in=5'b00010 → wEnable stays 0, psr=5'b00010. Then BEQ 16'hC0FE at pc=5 → pc=3. Repeat with Flags_in=0 → pc=6.
5. instr_valid held low 4 cycles in FETCH → fetch_req stays 1, pc constant, wEnable=0 throughout; accepts on first instr_valid=1.
6. HALT 16'hF000 → halted=1, fetch_req=0 indefinitely, no further wEnable. At pc=16'hFFFF, a NOP → pc wraps to 0.
